multicycle_cu: RTL and testbench
================================

# multicycle_cu

Multi-cycle control unit: the sequential successor of the single-cycle combinational decoder. It accepts one instruction per valid/ready handshake and latches it into an internal instruction register. A five-state FSM then steps it through decode, execute, memory and write-back. Memory strobes are held until a `mem_ready` acknowledge arrives, with a parametrised timeout, and a retired-instruction counter is kept. It sits between instruction fetch and the datapath (register file, ALU, data memory).

## Interface
- `ALU_OP_W`, 3: ALU op width; the op is taken from `instr[3+ALU_OP_W-1:3]`; legal range 1..8.
- `MEM_TIMEOUT`, 15: maximum cycles spent in MEM waiting for `mem_ready`; legal range 1..255.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  fetch offers `instr`.
- `instr`  in  32  encoding: opcode [31:26], rs1 [25:21], rs2 [20:16], rd [15:11], funct [10:3].
- `instr_ready`  out  1  high exactly in IDLE.
- `mem_ready`  in  1  data memory acknowledge.
- `alu_op`  out  ALU_OP_W  ALU operation.
- `rs1`, `rs2`, `rd`  out  5 each  register addresses.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `reg_write`  out  1  register-file write enable.
- `busy`  out  1  state != IDLE.
- `illegal`  out  1  unknown opcode flag.
- `fault`  out  1  memory timeout pulse.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Opcodes:
  - 000000: R-type.
  - 100011: LW.
  - 101011: SW.
  - anything else is illegal.
- States:
  - IDLE: on `instr_valid && instr_ready`, latch `instr` into IR and go to DECODE.
  - DECODE: always one cycle. R-type goes to EXEC; LW/SW go to MEM with the wait counter cleared; illegal goes to IDLE with `illegal`=1 during this DECODE cycle.
  - EXEC: one cycle, then WB.
  - MEM: `mem_read` (LW) or `mem_write` (SW) is held high for every MEM cycle. The wait counter increments each MEM cycle without `mem_ready`. When `mem_ready` is sampled high, LW goes to WB and SW goes to IDLE with a retire. If `mem_ready` is still low on the MEM_TIMEOUT-th MEM cycle, the access is aborted and the FSM goes to IDLE with no retire.
  - WB: `reg_write`=1 for one cycle, retire, go to IDLE.
- All outputs are decoded from state and IR only, with no combinational path from inputs. The `rst` path is asynchronous.
- Field outputs in every state except IDLE:
  - R-type: `rs1`, `rs2`, `rd` from IR.
  - LW: `rs1`, `rd` from IR; `rs2`=0.
  - SW: `rs1`, `rs2` from IR; `rd`=0.
  - Illegal: all field outputs 0.
- In IDLE all field outputs are 0.
- `alu_op` = IR funct slice in EXEC and WB of an R-type, else 0.
- `fault` is a registered one-cycle pulse in the first IDLE cycle after a timeout abort.
- `retired` increments by 1 on each retire (WB exit, or SW exit on `mem_ready`). It wraps modulo 2^CNT_W, never saturates, and is never incremented for illegal or aborted instructions.

## Timing
- Reset (asynchronous, immediate, valid mid-operation):
  - FSM to IDLE; IR, wait counter and `retired` cleared.
  - All outputs 0 except `instr_ready`=1.
  - Strobes drop without waiting for a clock edge; an in-flight access is dropped with no `fault`.
- Let cycle 0 be the accept edge. Issue-to-issue intervals:
  - R-type: DECODE c1, EXEC c2, WB c3, IDLE c4. Next accept at the end of c4, so 4 cycles per instruction.
  - LW with `mem_ready` high on the first MEM cycle: DECODE, MEM, WB, IDLE, i.e. 4 cycles. Each wait cycle adds 1.
  - SW with immediate ready: 3 cycles.
  - Illegal: 2 cycles.
- Simultaneous `mem_ready` and timeout on the same cycle: ready wins (normal completion, no `fault`).
- `instr_valid` outside IDLE is ignored, and `instr` may change freely then; it is not sampled.
- `mem_ready` outside MEM is ignored.

## Test plan
- Reset, then R-type `rs1`=3, `rs2`=4, `rd`=5, funct[5:3]=3'b010 -> `alu_op`=2 in EXEC and WB, `reg_write`=1 only in c3, `retired`=1, `instr_ready` back high at c4.
- LW with `mem_ready` delayed 3 cycles -> `mem_read` high for exactly 4 MEM cycles, `rs2`=0, one WB cycle, `retired`+1.
- SW with `MEM_TIMEOUT`=4 and `mem_ready` never asserted -> `mem_write` high 4 cycles, `fault` pulse in the next IDLE cycle, `retired` unchanged. Repeat with `mem_ready` on the 4th cycle -> no `fault`, `retired`+1.
- Opcode 6'b111111 -> `illegal`=1 for the single DECODE cycle, no strobes, `retired` unchanged, accept again 2 cycles after the first accept.
- `rst` asserted mid-MEM of an LW -> `mem_read` drops asynchronously, all outputs at reset values, no `fault` after release.
- `CNT_W`=4: 16 back-to-back SWs with immediate ready -> `retired` wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: latches one instruction per handshake and walks it
// through DECODE, EXEC/MEM and WB, driving registered datapath controls.
module multicycle_cu #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid_i,
  input  logic [31:0]         instr_i,
  output logic                instr_ready_o,
  input  logic                mem_ready_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [4:0]          rd_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                reg_write_o,
  output logic                busy_o,
  output logic                illegal_o,
  output logic                fault_o,
  output logic [CNT_W-1:0]    retired_o
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_e;
  typedef enum logic [1:0] {K_R, K_LW, K_SW, K_ILL} kind_e;

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic                instrReady;
    logic                busy;
    logic                illegal;
    logic                memRead;
    logic                memWrite;
    logic                regWrite;
    logic [ALU_OP_W-1:0] aluOp;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
  } ctl_t;

  function automatic kind_e kindOf(input logic [31:0] ir);
    kind_e k;
    case (ir[31:26])
      OP_R:    k = K_R;
      OP_LW:   k = K_LW;
      OP_SW:   k = K_SW;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // Controls are a pure function of (state, IR) and are registered on entry
  // to the state, so no input ever reaches an output combinationally.
  function automatic ctl_t ctlFor(input state_e st, input logic [31:0] ir);
    ctl_t c;
    c = '0;
    c.instrReady = (st == IDLE);
    c.busy       = (st != IDLE);
    if (st != IDLE) begin
      case (kindOf(ir))
        K_R: begin
          c.rs1 = ir[25:21];
          c.rs2 = ir[20:16];
          c.rd  = ir[15:11];
          if (st == EXEC || st == WB) c.aluOp = ir[3 +: ALU_OP_W];
        end
        K_LW: begin
          c.rs1     = ir[25:21];
          c.rd      = ir[15:11];
          c.memRead = (st == MEM);
        end
        K_SW: begin
          c.rs1      = ir[25:21];
          c.rs2      = ir[20:16];
          c.memWrite = (st == MEM);
        end
        default: c.illegal = (st == DECODE);
      endcase
      c.regWrite = (st == WB);
    end
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fault_q, fault_d;
  ctl_t             ctl_q, ctl_d;

  // Next-state logic; a memory acknowledge takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    fault_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          ir_d    = instr_i;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (kindOf(ir_q))
          K_R:  state_d = EXEC;
          K_LW, K_SW: begin
            state_d = MEM;
            wait_d  = 8'd0;
          end
          default: state_d = IDLE;
        endcase
      end
      EXEC: state_d = WB;
      MEM: begin
        if (mem_ready_i) begin
          if (kindOf(ir_q) == K_LW) begin
            state_d = WB;
          end else begin
            state_d   = IDLE;
            retired_d = retired_q + CNT_W'(1);
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        state_d   = IDLE;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    ctl_d = ctlFor(state_d, ir_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      ctl_q     <= ctlFor(IDLE, 32'd0);
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      ctl_q     <= ctl_d;
    end
  end

  assign instr_ready_o = ctl_q.instrReady;
  assign busy_o        = ctl_q.busy;
  assign illegal_o     = ctl_q.illegal;
  assign mem_read_o    = ctl_q.memRead;
  assign mem_write_o   = ctl_q.memWrite;
  assign reg_write_o   = ctl_q.regWrite;
  assign alu_op_o      = ctl_q.aluOp;
  assign rs1_o         = ctl_q.rs1;
  assign rs2_o         = ctl_q.rs2;
  assign rd_o          = ctl_q.rd;
  assign fault_o       = fault_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: each instruction is expanded into its expected
// per-cycle output trace from the phase rules, and every cycle is compared.
module tb_multicycle_cu;

  localparam int ALU_OP_W    = 3;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam int PH_IDLE = 0, PH_DECODE = 1, PH_EXEC = 2, PH_MEM = 3, PH_WB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instrValid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        memReady = 1'b0;

  logic                instrReady, memRead, memWrite, regWrite, busy, illegal, fault;
  logic [ALU_OP_W-1:0] aluOp;
  logic [4:0]          rs1, rs2, rd;
  logic [CNT_W-1:0]    retired;

  multicycle_cu #(.ALU_OP_W(ALU_OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instrValid), .instr_i(instr), .instr_ready_o(instrReady),
    .mem_ready_i(memReady), .alu_op_o(aluOp),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .mem_read_o(memRead), .mem_write_o(memWrite), .reg_write_o(regWrite),
    .busy_o(busy), .illegal_o(illegal), .fault_o(fault), .retired_o(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       instrReady, busy, illegal, memRead, memWrite, regWrite, fault;
    logic [2:0] aluOp;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] retired;
  } vec_t;

  vec_t dutNow;
  assign dutNow = {instrReady, busy, illegal, memRead, memWrite, regWrite, fault,
                   aluOp, rs1, rs2, rd, retired};

  vec_t       expQ[$];
  vec_t       hist[0:8191];
  int         tests = 0;
  int         fails = 0;
  int         cycleCount = 0;
  logic [3:0] modelRetired = 4'd0;

  // Outputs expected while an instruction sits in a given phase.
  function automatic vec_t phaseVec(input int ph, input logic [31:0] ins,
                                    input logic [3:0] ret, input logic flt);
    vec_t v;
    logic [5:0] op;
    v = '0;
    op = ins[31:26];
    v.retired = ret;
    v.fault   = flt;
    if (ph == PH_IDLE) begin
      v.instrReady = 1'b1;
      return v;
    end
    v.busy     = 1'b1;
    v.regWrite = (ph == PH_WB);
    if (op == OP_R) begin
      v.rs1 = ins[25:21]; v.rs2 = ins[20:16]; v.rd = ins[15:11];
      if (ph == PH_EXEC || ph == PH_WB) v.aluOp = ins[5:3];
    end else if (op == OP_LW) begin
      v.rs1 = ins[25:21]; v.rd = ins[15:11];
      v.memRead = (ph == PH_MEM);
    end else if (op == OP_SW) begin
      v.rs1 = ins[25:21]; v.rs2 = ins[20:16];
      v.memWrite = (ph == PH_MEM);
    end else begin
      v.illegal = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c,
                                          input logic [7:0] f);
    return {op, a, b, c, f, 3'b000};
  endfunction

  function automatic logic rndBit();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(negedge clk) hist[cycleCount % 8192] <= dutNow;

  // Single compare process: one expected vector per cycle after each edge.
  always @(posedge clk) begin
    vec_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      tests++;
      if (dutNow !== e) begin
        fails++;
        $display("[TB] FAIL cycle %0d outputs: got %h expected %h", cycleCount, dutNow, e);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic mr,
                               input vec_t e);
    @(negedge clk);
    instrValid = v;
    instr      = ins;
    memReady   = mr;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, $urandom, rndBit(),
                             phaseVec(PH_IDLE, 32'd0, modelRetired, 1'b0));
  endtask

  // readyAt: MEM cycle (1-based) on which mem_ready is high; 0 means never.
  task automatic runInstr(input logic [31:0] ins, input int readyAt, output int acc);
    logic [5:0] op;
    op = ins[31:26];
    applyStimulus(1'b1, ins, rndBit(), phaseVec(PH_DECODE, ins, modelRetired, 1'b0));
    acc = cycleCount;
    if (op == OP_R) begin
      applyStimulus(rndBit(), $urandom, rndBit(), phaseVec(PH_EXEC, ins, modelRetired, 1'b0));
      applyStimulus(rndBit(), $urandom, rndBit(), phaseVec(PH_WB, ins, modelRetired, 1'b0));
      modelRetired++;
      applyStimulus(rndBit(), $urandom, rndBit(), phaseVec(PH_IDLE, ins, modelRetired, 1'b0));
    end else if (op == OP_LW || op == OP_SW) begin
      applyStimulus(rndBit(), $urandom, rndBit(), phaseVec(PH_MEM, ins, modelRetired, 1'b0));
      for (int k = 1; k <= MEM_TIMEOUT; k++) begin
        if (k == readyAt) begin
          if (op == OP_LW) begin
            applyStimulus(rndBit(), $urandom, 1'b1, phaseVec(PH_WB, ins, modelRetired, 1'b0));
            modelRetired++;
            applyStimulus(rndBit(), $urandom, rndBit(),
                          phaseVec(PH_IDLE, ins, modelRetired, 1'b0));
          end else begin
            modelRetired++;
            applyStimulus(rndBit(), $urandom, 1'b1, phaseVec(PH_IDLE, ins, modelRetired, 1'b0));
          end
          break;
        end else if (k == MEM_TIMEOUT) begin
          applyStimulus(rndBit(), $urandom, 1'b0, phaseVec(PH_IDLE, ins, modelRetired, 1'b1));
        end else begin
          applyStimulus(rndBit(), $urandom, 1'b0, phaseVec(PH_MEM, ins, modelRetired, 1'b0));
        end
      end
    end else begin
      applyStimulus(rndBit(), $urandom, rndBit(), phaseVec(PH_IDLE, ins, modelRetired, 1'b0));
    end
  endtask

  initial begin
    int a, b, cnt, gap, kind;
    logic [5:0]  op;
    logic [31:0] ins;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset instr_ready", int'(instrReady), 1);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset retired", int'(retired), 0);
    checkOutput("reset strobes", int'({memRead, memWrite, regWrite, illegal, fault}), 0);
    rst = 1'b0;
    modelRetired = 4'd0;
    idleCycles(2);

    runInstr(mkInstr(OP_R, 5'd3, 5'd4, 5'd5, 8'h02), 0, a);
    idleCycles(2);
    checkOutput("rtype alu_op decode", int'(hist[a+1].aluOp), 0);
    checkOutput("rtype alu_op exec", int'(hist[a+2].aluOp), 2);
    checkOutput("rtype alu_op wb", int'(hist[a+3].aluOp), 2);
    checkOutput("rtype rs1", int'(hist[a+2].rs1), 3);
    checkOutput("rtype rs2", int'(hist[a+2].rs2), 4);
    checkOutput("rtype rd", int'(hist[a+2].rd), 5);
    checkOutput("rtype reg_write c2", int'(hist[a+2].regWrite), 0);
    checkOutput("rtype reg_write c3", int'(hist[a+3].regWrite), 1);
    checkOutput("rtype reg_write c4", int'(hist[a+4].regWrite), 0);
    checkOutput("rtype instr_ready c3", int'(hist[a+3].instrReady), 0);
    checkOutput("rtype instr_ready c4", int'(hist[a+4].instrReady), 1);
    checkOutput("rtype retired c4", int'(hist[a+4].retired), 1);

    runInstr(mkInstr(OP_LW, 5'd7, 5'd9, 5'd11, 8'h00), 4, a);
    idleCycles(2);
    cnt = 0;
    for (int i = 1; i <= 8; i++) cnt += int'(hist[a+i].memRead);
    checkOutput("lw mem_read cycles", cnt, 4);
    checkOutput("lw rs2", int'(hist[a+2].rs2), 0);
    checkOutput("lw rd", int'(hist[a+2].rd), 11);
    checkOutput("lw reg_write in wb", int'(hist[a+6].regWrite), 1);
    cnt = 0;
    for (int i = 1; i <= 8; i++) cnt += int'(hist[a+i].regWrite);
    checkOutput("lw reg_write cycles", cnt, 1);
    checkOutput("lw retired", int'(hist[a+7].retired), 2);

    runInstr(mkInstr(OP_SW, 5'd1, 5'd2, 5'd0, 8'h00), 0, a);
    idleCycles(2);
    cnt = 0;
    for (int i = 1; i <= 8; i++) cnt += int'(hist[a+i].memWrite);
    checkOutput("sw timeout mem_write cycles", cnt, 4);
    checkOutput("sw timeout fault", int'(hist[a+6].fault), 1);
    checkOutput("sw timeout fault cleared", int'(hist[a+7].fault), 0);
    checkOutput("sw timeout retired", int'(hist[a+6].retired), 2);

    runInstr(mkInstr(OP_SW, 5'd1, 5'd2, 5'd0, 8'h00), 4, a);
    idleCycles(2);
    cnt = 0;
    for (int i = 1; i <= 8; i++) cnt += int'(hist[a+i].memWrite);
    checkOutput("sw ready4 mem_write cycles", cnt, 4);
    cnt = 0;
    for (int i = 1; i <= 8; i++) cnt += int'(hist[a+i].fault);
    checkOutput("sw ready4 no fault", cnt, 0);
    checkOutput("sw ready4 retired", int'(hist[a+6].retired), 3);

    runInstr(mkInstr(6'b111111, 5'd8, 5'd9, 5'd10, 8'h05), 0, a);
    runInstr(mkInstr(OP_R, 5'd1, 5'd1, 5'd1, 8'h01), 0, b);
    idleCycles(2);
    checkOutput("illegal flag decode", int'(hist[a+1].illegal), 1);
    checkOutput("illegal flag after", int'(hist[a+2].illegal), 0);
    checkOutput("illegal strobes", int'({hist[a+1].memRead, hist[a+1].memWrite}), 0);
    checkOutput("illegal fields", int'({hist[a+1].rs1, hist[a+1].rs2, hist[a+1].rd}), 0);
    checkOutput("illegal retired", int'(hist[a+2].retired), 3);
    checkOutput("illegal ready c2", int'(hist[a+2].instrReady), 1);
    checkOutput("illegal next accept busy c3", int'(hist[a+3].busy), 1);

    ins = mkInstr(OP_LW, 5'd4, 5'd6, 5'd8, 8'h00);
    applyStimulus(1'b1, ins, 1'b0, phaseVec(PH_DECODE, ins, modelRetired, 1'b0));
    applyStimulus(1'b0, 32'd0, 1'b0, phaseVec(PH_MEM, ins, modelRetired, 1'b0));
    applyStimulus(1'b0, 32'd0, 1'b0, phaseVec(PH_MEM, ins, modelRetired, 1'b0));
    @(negedge clk);
    checkOutput("mid-mem mem_read before reset", int'(memRead), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset mem_read", int'(memRead), 0);
    checkOutput("async reset instr_ready", int'(instrReady), 1);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset retired", int'(retired), 0);
    checkOutput("async reset fields", int'({rs1, rs2, rd}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelRetired = 4'd0;
    idleCycles(3);
    checkOutput("no fault after reset", int'(fault), 0);

    for (int i = 0; i < 16; i++) begin
      runInstr(mkInstr(OP_SW, 5'(i), 5'(i + 1), 5'd0, 8'h00), 1, a);
      if (i == 15) b = a;
    end
    idleCycles(2);
    checkOutput("wrap retired before", int'(hist[b+2].retired), 15);
    checkOutput("wrap retired after", int'(hist[b+3].retired), 0);

    repeat (300) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        default: begin
          op = 6'($urandom);
          if (op == OP_R || op == OP_LW || op == OP_SW) op = 6'b111111;
        end
      endcase
      ins = $urandom;
      ins[31:26] = op;
      runInstr(ins, $urandom_range(0, 6), a);
      gap = $urandom_range(0, 2);
      idleCycles(gap);
    end
    idleCycles(2);
    instrValid = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("expected queue drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
